mainmem_backdoor_arbiter: RTL and testbench

//  Multi-channel successor to the single-thread main-memory backdoor tasks. It takes

---
 rtl/mainmem_backdoor_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_mainmem_backdoor_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mainmem_backdoor_arbiter.sv
// Clocked multi-channel backdoor engine for main memory: round-robin grants whole
// bursts to one channel at a time and drives the scratchpad through an override mux.
module mainmem_backdoor_arbiter #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned RD_LAT    = 1,
  localparam int unsigned BE_W     = DATA_W / 8,
  localparam int unsigned LEN_W    = $clog2(MAX_BURST),
  localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req_valid,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic [NUM_CH-1:0]        req_write,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*LEN_W-1:0]  req_len,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  input  logic [NUM_CH*BE_W-1:0]   req_mask,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [CH_W-1:0]          rsp_ch,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_last,
  input  logic                     mem_busy,
  output logic                     mem_override,
  output logic                     mem_write,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic [BE_W-1:0]          mem_mask,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [31:0]              wr_beats,
  output logic [31:0]              rd_beats
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR       = 3'd1;
  localparam logic [2:0] S_RD_ISSUE = 3'd2;
  localparam logic [2:0] S_RD_WAIT  = 3'd3;
  localparam logic [2:0] S_RSP      = 3'd4;

  localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  logic [2:0]        state_q, state_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [31:0]       wr_beats_q, rd_beats_q;
  logic              wr_inc, rd_inc;

  logic              gnt_found;
  logic [CH_W-1:0]   gnt_ch;
  logic [CH_W-1:0]   sel_ch;
  logic [ADDR_W-1:0] g_addr;
  logic [LEN_W-1:0]  g_len;
  logic              g_write;
  logic [DATA_W-1:0] sel_wdata;
  logic [BE_W-1:0]   sel_mask;

  // First valid channel at or after rr_ptr, searching with wrap-around.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_ch    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = (32'(rr_ptr_q) + i) % NUM_CH;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_ch    = CH_W'(idx);
      end
    end
  end

  // Write data comes from the grant candidate in IDLE, from the owner otherwise.
  assign sel_ch    = (state_q == S_IDLE) ? gnt_ch : ch_q;
  assign g_addr    = req_addr[gnt_ch*ADDR_W +: ADDR_W];
  assign g_len     = req_len[gnt_ch*LEN_W +: LEN_W];
  assign g_write   = req_write[gnt_ch];
  assign sel_wdata = req_wdata[sel_ch*DATA_W +: DATA_W];
  assign sel_mask  = req_mask[sel_ch*BE_W +: BE_W];

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    ch_d         = ch_q;
    addr_d       = addr_q;
    len_d        = len_q;
    beat_d       = beat_q;
    rdata_d      = rdata_q;
    lat_d        = lat_q;
    req_ready    = '0;
    rsp_valid    = 1'b0;
    rsp_ch       = '0;
    rsp_rdata    = '0;
    rsp_last     = 1'b0;
    mem_override = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_mask     = '0;
    wr_inc       = 1'b0;
    rd_inc       = 1'b0;
    // Outputs are held at zero while reset is asserted so no grant is visible.
    if (!rst) begin
      unique case (state_q)
        S_IDLE: begin
          if (!mem_busy && gnt_found) begin
            req_ready[gnt_ch] = 1'b1;
            ch_d              = gnt_ch;
            len_d             = g_len;
            rr_ptr_d          = (32'(gnt_ch) == NUM_CH - 1) ? '0 : gnt_ch + 1'b1;
            if (g_write) begin
              mem_override = 1'b1;
              mem_write    = 1'b1;
              mem_addr     = g_addr;
              mem_wdata    = sel_wdata;
              mem_mask     = sel_mask;
              wr_inc       = 1'b1;
              addr_d       = g_addr + ADDR_W'(BE_W);
              beat_d       = LEN_W'(1);
              state_d      = (g_len == '0) ? S_IDLE : S_WR;
            end else begin
              addr_d  = g_addr;
              beat_d  = '0;
              state_d = S_RD_ISSUE;
            end
          end
        end
        S_WR: begin
          if (req_valid[ch_q] && !mem_busy) begin
            req_ready[ch_q] = 1'b1;
            mem_override    = 1'b1;
            mem_write       = 1'b1;
            mem_addr        = addr_q;
            mem_wdata       = sel_wdata;
            mem_mask        = sel_mask;
            wr_inc          = 1'b1;
            addr_d          = addr_q + ADDR_W'(BE_W);
            beat_d          = beat_q + 1'b1;
            if (beat_q == len_q) state_d = S_IDLE;
          end
        end
        S_RD_ISSUE: begin
          if (!mem_busy) begin
            mem_override = 1'b1;
            mem_addr     = addr_q;
            lat_d        = '0;
            state_d      = S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          mem_override = 1'b1;
          mem_addr     = addr_q;
          if (32'(lat_q) == RD_LAT - 1) begin
            rdata_d = mem_rdata;
            state_d = S_RSP;
          end else begin
            lat_d = lat_q + 1'b1;
          end
        end
        S_RSP: begin
          rsp_valid = 1'b1;
          rsp_ch    = ch_q;
          rsp_rdata = rdata_q;
          rsp_last  = (beat_q == len_q);
          if (rsp_ready) begin
            rd_inc = 1'b1;
            if (beat_q == len_q) begin
              state_d = S_IDLE;
            end else begin
              addr_d  = addr_q + ADDR_W'(BE_W);
              beat_d  = beat_q + 1'b1;
              state_d = S_RD_ISSUE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      ch_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      rdata_q    <= '0;
      lat_q      <= '0;
      wr_beats_q <= '0;
      rd_beats_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      ch_q     <= ch_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      rdata_q  <= rdata_d;
      lat_q    <= lat_d;
      if (wr_inc && (wr_beats_q != '1)) wr_beats_q <= wr_beats_q + 32'd1;
      if (rd_inc && (rd_beats_q != '1)) rd_beats_q <= rd_beats_q + 32'd1;
    end
  end

  assign wr_beats = wr_beats_q;
  assign rd_beats = rd_beats_q;

endmodule

// File: tb/tb_mainmem_backdoor_arbiter.sv
// Directed bench for mainmem_backdoor_arbiter: scratchpad model with RD_LAT=1 returning
// {~addr, addr}, a write log, and one task per scenario with hand-computed expectations.
module tb_mainmem_backdoor_arbiter;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req_valid, req_ready, req_write;
  logic [127:0]  req_addr;
  logic [15:0]   req_len;
  logic [255:0]  req_wdata;
  logic [31:0]   req_mask;
  logic          rsp_valid, rsp_ready, rsp_last;
  logic [1:0]    rsp_ch;
  logic [63:0]   rsp_rdata;
  logic          mem_busy, mem_override, mem_write;
  logic [31:0]   mem_addr;
  logic [63:0]   mem_wdata, mem_rdata;
  logic [7:0]    mem_mask;
  logic [31:0]   wr_beats, rd_beats;

  int vectors = 0;
  int miscompares = 0;

  mainmem_backdoor_arbiter #(
    .NUM_CH(4), .ADDR_W(32), .DATA_W(64), .MAX_BURST(16), .RD_LAT(1)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata), .req_mask(req_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ch(rsp_ch),
    .rsp_rdata(rsp_rdata), .rsp_last(rsp_last),
    .mem_busy(mem_busy), .mem_override(mem_override), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
    .mem_rdata(mem_rdata), .wr_beats(wr_beats), .rd_beats(rd_beats)
  );

  always #5 clk = ~clk;

  // Scratchpad model: one-cycle read latency, data pattern derived from address.
  logic [31:0] rd_addr_q = '0;
  always @(posedge clk) if (mem_override === 1'b1 && mem_write === 1'b0) rd_addr_q <= mem_addr;
  assign mem_rdata = {~rd_addr_q, rd_addr_q};

  logic [31:0] wlog_addr[$];
  logic [63:0] wlog_data[$];
  always @(posedge clk) begin
    if (mem_override === 1'b1 && mem_write === 1'b1) begin
      wlog_addr.push_back(mem_addr);
      wlog_data.push_back(mem_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_write = '0; req_addr = '0; req_len = '0;
    req_wdata = '0; req_mask = '0; rsp_ready = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    wlog_addr.delete();
    wlog_data.delete();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    req_valid = 4'b1111; req_write = 4'b1111;
    tick(); tick();
    vectors++;
    if (req_ready !== 4'b0000 || mem_override !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_gate: ready=%b override=%b, want ready=0000 override=0", req_ready, mem_override);
    end
    req_valid = '0; req_write = '0;
    tick();
    rst = 1'b0;
    #1;
    vectors++;
    if ({rsp_valid, rsp_last, mem_override, mem_write} !== 4'b0 || rsp_ch !== 2'd0 ||
        rsp_rdata !== 64'd0 || mem_addr !== 32'd0 || mem_wdata !== 64'd0 || mem_mask !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%b last=%b ovr=%b wr=%b addr=%h, want all 0",
               rsp_valid, rsp_last, mem_override, mem_write, mem_addr);
    end
    vectors++;
    if (wr_beats !== 32'd0 || rd_beats !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_counters: wr=%0d rd=%0d, want 0 0", wr_beats, rd_beats);
    end
    tick();
  endtask

  task automatic test_single_write();
    wlog_addr.delete(); wlog_data.delete();
    req_valid = 4'b0001; req_write = 4'b0001;
    req_addr[31:0] = 32'h8000_0000; req_len[3:0] = 4'd0;
    req_wdata[63:0] = 64'hDEADBEEF_CAFEF00D; req_mask[7:0] = 8'hFF;
    #1;
    vectors++;
    if (req_ready !== 4'b0001 || mem_override !== 1'b1 || mem_write !== 1'b1) begin
      miscompares++;
      $display("FAIL sw_grant: ready=%b ovr=%b wr=%b, want 0001 1 1", req_ready, mem_override, mem_write);
    end
    vectors++;
    if (mem_addr !== 32'h8000_0000 || mem_wdata !== 64'hDEADBEEF_CAFEF00D || mem_mask !== 8'hFF) begin
      miscompares++;
      $display("FAIL sw_bus: addr=%h data=%h mask=%h, want 80000000 deadbeefcafef00d ff",
               mem_addr, mem_wdata, mem_mask);
    end
    tick();
    req_valid = '0; req_write = '0;
    #1;
    vectors++;
    if (wlog_addr.size() != 1 || wlog_addr[0] !== 32'h8000_0000 || wlog_data[0] !== 64'hDEADBEEF_CAFEF00D) begin
      miscompares++;
      $display("FAIL sw_log: writes=%0d, want 1 write at 80000000", wlog_addr.size());
    end
    vectors++;
    if (wr_beats !== 32'd1 || mem_override !== 1'b0) begin
      miscompares++;
      $display("FAIL sw_after: wr_beats=%0d ovr=%b, want 1 0", wr_beats, mem_override);
    end
  endtask

  task automatic test_read_burst();
    int n;
    logic [31:0] exp_a;
    n = 0;
    req_valid = 4'b0100; req_write = 4'b0000;
    req_addr[64 +: 32] = 32'h100; req_len[8 +: 4] = 4'd3; rsp_ready = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 4'b0100 || mem_override !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_grant: ready=%b ovr=%b, want 0100 0", req_ready, mem_override);
    end
    tick();
    req_valid = '0;
    for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
      #1;
      if (rsp_valid === 1'b1) begin
        exp_a = 32'h100 + 32'(8 * n);
        vectors++;
        if (rsp_ch !== 2'd2 || rsp_rdata !== {~exp_a, exp_a} || rsp_last !== (n == 3)) begin
          miscompares++;
          $display("FAIL rd_beat[%0d]: ch=%0d data=%h last=%b, want ch=2 data=%h last=%b",
                   n, rsp_ch, rsp_rdata, rsp_last, {~exp_a, exp_a}, (n == 3));
        end
        n++;
      end
      tick();
    end
    vectors++;
    if (n != 4 || rd_beats !== 32'd4) begin
      miscompares++;
      $display("FAIL rd_count: beats seen=%0d rd_beats=%0d, want 4 4", n, rd_beats);
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    int exp_ch[6];
    exp_ch = '{0, 1, 2, 3, 0, 1};
    do_reset();
    req_valid = 4'b1111; req_write = 4'b1111; req_len = '0; req_mask = '1;
    for (int c = 0; c < 4; c++) begin
      req_addr[c*32 +: 32]  = 32'h1000 + 32'(c * 64);
      req_wdata[c*64 +: 64] = {32'hC0DE_0000 + 32'(c), 32'h0};
    end
    #1;
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (req_ready !== 4'(1 << exp_ch[i]) || mem_addr !== 32'h1000 + 32'(exp_ch[i] * 64)) begin
        miscompares++;
        $display("FAIL rr_grant[%0d]: ready=%b addr=%h, want ready=%b addr=%h", i, req_ready,
                 mem_addr, 4'(1 << exp_ch[i]), 32'h1000 + 32'(exp_ch[i] * 64));
      end
      tick();
      if (exp_ch[i] >= 2) req_valid[exp_ch[i]] = 1'b0;
      #1;
    end
    req_valid = '0; req_write = '0;
    vectors++;
    if (wr_beats !== 32'd6) begin
      miscompares++;
      $display("FAIL rr_count: wr_beats=%0d, want 6", wr_beats);
    end
  endtask

  task automatic test_stall();
    int b;
    logic acc;
    b = 0;
    do_reset();
    req_valid = 4'b0010; req_write = 4'b0010;
    req_addr[32 +: 32] = 32'h2000; req_len[4 +: 4] = 4'd7; req_mask[8 +: 8] = 8'h3C;
    for (int cyc = 0; cyc < 40 && b < 8; cyc++) begin
      mem_busy = (cyc >= 3 && cyc < 8);
      req_wdata[64 +: 64] = 64'hA5A5_0000_0000_0000 + 64'(b);
      #1;
      acc = (req_ready[1] === 1'b1);
      vectors++;
      if (mem_busy) begin
        if (mem_override !== 1'b0 || req_ready !== 4'b0000) begin
          miscompares++;
          $display("FAIL stall_cyc[%0d]: ovr=%b ready=%b, want 0 0000", cyc, mem_override, req_ready);
        end
      end else if (req_ready !== 4'b0010 || mem_override !== 1'b1 || mem_write !== 1'b1 ||
                   mem_addr !== 32'h2000 + 32'(8 * b) || mem_wdata !== 64'hA5A5_0000_0000_0000 + 64'(b) ||
                   mem_mask !== 8'h3C) begin
        miscompares++;
        $display("FAIL stall_beat[%0d]: ready=%b ovr=%b wr=%b addr=%h data=%h, want 0010 1 1 %h %h",
                 b, req_ready, mem_override, mem_write, mem_addr, mem_wdata,
                 32'h2000 + 32'(8 * b), 64'hA5A5_0000_0000_0000 + 64'(b));
      end
      tick();
      if (acc) b++;
    end
    req_valid = '0; req_write = '0; mem_busy = 1'b0;
    #1;
    vectors++;
    if (b != 8 || wr_beats !== 32'd8 || wlog_addr.size() != 8 || wlog_addr[7] !== 32'h2038) begin
      miscompares++;
      $display("FAIL stall_total: beats=%0d wr_beats=%0d logged=%0d, want 8 8 8 (last 2038)",
               b, wr_beats, wlog_addr.size());
    end
  endtask

  task automatic test_wrap_backpressure();
    logic found, saw;
    logic [31:0] issued;
    logic [63:0] first_data;
    found = 1'b0; saw = 1'b0; issued = '0; first_data = '0;
    do_reset();
    req_valid = 4'b1000; req_write = 4'b0000;
    req_addr[96 +: 32] = 32'hFFFF_FFF8; req_len[12 +: 4] = 4'd1; rsp_ready = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 4'b1000) begin
      miscompares++;
      $display("FAIL wrap_grant: ready=%b, want 1000", req_ready);
    end
    tick();
    req_valid = '0;
    for (int cyc = 0; cyc < 20 && !found; cyc++) begin
      #1;
      if (rsp_valid === 1'b1) found = 1'b1;
      else tick();
    end
    first_data = rsp_rdata;
    vectors++;
    if (!found || rsp_rdata !== 64'h0000_0007_FFFF_FFF8 || rsp_last !== 1'b0 || rsp_ch !== 2'd3) begin
      miscompares++;
      $display("FAIL wrap_beat0: seen=%b data=%h last=%b ch=%0d, want 1 00000007fffffff8 0 3",
               found, rsp_rdata, rsp_last, rsp_ch);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 64'h0000_0007_FFFF_FFF8) begin
        miscompares++;
        $display("FAIL wrap_hold[%0d]: valid=%b data=%h, want 1 00000007fffffff8", k, rsp_valid, rsp_rdata);
      end
    end
    rsp_ready = 1'b1;
    tick();
    found = 1'b0;
    for (int cyc = 0; cyc < 20 && !found; cyc++) begin
      #1;
      if (!saw && mem_override === 1'b1 && mem_write === 1'b0) begin
        saw = 1'b1;
        issued = mem_addr;
      end
      if (rsp_valid === 1'b1) found = 1'b1;
      else tick();
    end
    vectors++;
    if (!saw || issued !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_addr: issued=%b addr=%h, want 1 00000000", saw, issued);
    end
    vectors++;
    if (!found || rsp_rdata !== 64'hFFFF_FFFF_0000_0000 || rsp_last !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_beat1: seen=%b data=%h last=%b, want 1 ffffffff00000000 1",
               found, rsp_rdata, rsp_last);
    end
    tick();
    vectors++;
    if (rsp_valid !== 1'b0 || rd_beats !== 32'd2) begin
      miscompares++;
      $display("FAIL wrap_done: valid=%b rd_beats=%0d, want 0 2", rsp_valid, rd_beats);
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    int n;
    logic hit;
    n = 0; hit = 1'b0;
    do_reset();
    req_valid = 4'b0100; req_write = 4'b0000;
    req_addr[64 +: 32] = 32'h300; req_len[8 +: 4] = 4'd5; rsp_ready = 1'b1;
    tick();
    req_valid = '0;
    for (int cyc = 0; cyc < 40 && !hit; cyc++) begin
      #1;
      if (rsp_valid === 1'b1 && n == 1) hit = 1'b1;
      else begin
        if (rsp_valid === 1'b1) n++;
        tick();
      end
    end
    vectors++;
    if (!hit || rsp_rdata !== {~32'h308, 32'h308}) begin
      miscompares++;
      $display("FAIL rst_mid_beat2: seen=%b data=%h, want 1 %h", hit, rsp_rdata, {~32'h308, 32'h308});
    end
    rst = 1'b1;
    tick();
    #1;
    vectors++;
    if ({rsp_valid, rsp_last, mem_override, mem_write} !== 4'b0 || req_ready !== 4'b0 ||
        rsp_rdata !== 64'd0 || mem_addr !== 32'd0 || wr_beats !== 32'd0 || rd_beats !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: valid=%b ovr=%b ready=%b addr=%h rd=%0d, want all 0",
               rsp_valid, mem_override, req_ready, mem_addr, rd_beats);
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (rsp_valid !== 1'b0 || req_ready !== 4'b0 || mem_override !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_mid_quiet[%0d]: valid=%b ready=%b ovr=%b, want 0 0000 0",
                 k, rsp_valid, req_ready, mem_override);
      end
    end
    req_valid = 4'b1001; req_write = 4'b1001; req_len = '0; req_mask = '1;
    req_addr[0 +: 32] = 32'h4000; req_addr[96 +: 32] = 32'h4300;
    #1;
    vectors++;
    if (req_ready !== 4'b0001 || mem_addr !== 32'h4000) begin
      miscompares++;
      $display("FAIL rst_mid_regrant: ready=%b addr=%h, want 0001 00004000", req_ready, mem_addr);
    end
    tick();
    req_valid = '0; req_write = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_single_write();
    test_read_burst();
    test_round_robin();
    test_stall();
    test_wrap_backpressure();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
